// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter: word accepted at edge k appears as bits in cycles k+1..k+WIDTH.
// Backpressure: ready only in IDLE or on the last bit of a word; load while not ready is dropped.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    output logic             ready,
    output logic             dout,
    output logic             dout_bar,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             last_bit
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic             at_last;
    logic             accept;
    logic             out_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign at_last = (cnt_q == CNT_LAST);
    assign ready   = (state_q == IDLE) || at_last;
    assign accept  = load && ready;

    // Shift toward the output end, zero-filling the vacated bit.
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};
    assign out_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = pdata;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (load) begin
                        // Reload on the final bit keeps the stream gapless.
                        shreg_d = pdata;
                    end else begin
                        shreg_d = shreg_shifted;
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout_valid  = (state_q == SHIFT);
    assign dout        = dout_valid && out_bit;
    assign dout_bar    = ~dout;
    assign frame_start = dout_valid && (cnt_q == '0);
    assign last_bit    = dout_valid && at_last;

endmodule
